// File: rtl/multicycle_seq.sv
// multicycle_seq -- control FSM for a multi-cycle processor datapath.
//
// Walks each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB)
// and drives the datapath control strobes for the current cycle. The strobes
// are decoded from the registered state and the live inputs, because the
// memory-ack cycle must raise ir_we/pc_we in that same cycle.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   inst         instruction register contents, opcode = inst[31:28]
//   alu_z/alu_n  ALU zero/negative flags, meaningful during EXEC
//   mem_ack      memory completes the current request this cycle
//   mem_req      memory request
//   mem_we       memory write enable
//   addr_sel     memory address source (1 = PC, 0 = ALU result)
//   ir_we        instruction register load
//   pc_we        PC load
//   pc_src       PC source (0 = PC+1, 1 = register target)
//   reg_we       register file write enable
//   reg_src      register write data source (0 = ALU, 1 = memory)
//   alusrc       ALU operand B select
//   aluop        ALU operation
//   retire       one-cycle pulse in the final cycle of an instruction
//   retired_cnt  count of completed instructions (wraps)
//   state        current FSM state code, for observation
//
// Memory handshake: mem_req is held high for the whole FETCH or MEM state;
// the request completes in the cycle where mem_req and mem_ack are both high.
// mem_ack is ignored in every other state.
module multicycle_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        reg_we,
  output logic        reg_src,
  output logic        alusrc,
  output logic [2:0]  aluop,
  output logic        retire,
  output logic [15:0] retired_cnt,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        z_q;
  logic        n_q;
  logic [15:0] cnt_q;

  logic [3:0]  op;
  logic        is_alu;
  logic        is_load;
  logic        is_store;
  logic        is_j;
  logic        is_brz;
  logic        is_brn;
  logic        is_svpc;
  logic        unused_inst;

  assign op          = inst[31:28];
  assign unused_inst = ^inst[27:0];

  assign is_alu   = (op[3:2] == 2'b01);
  assign is_load  = (op == 4'b1110);
  assign is_store = (op == 4'b0011);
  assign is_j     = (op == 4'b1000);
  assign is_brz   = (op == 4'b1001);
  assign is_brn   = (op == 4'b1011);
  assign is_svpc  = (op == 4'b1111);

  // Opcode is only looked at outside FETCH, so the IR may change freely
  // while an instruction is being fetched.
  always_comb begin
    state_d  = S_FETCH;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 1'b0;
    reg_we   = 1'b0;
    reg_src  = 1'b0;
    alusrc   = 1'b0;
    aluop    = 3'b000;
    retire   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_alu) begin
          case (op[1:0])
            2'b10:   aluop = 3'b010;
            2'b11:   aluop = 3'b001;
            default: aluop = 3'b100;
          endcase
          alusrc  = (op[1:0] == 2'b01);
          state_d = S_WB;
        end else if (is_svpc) begin
          aluop   = 3'b100;
          alusrc  = 1'b1;
          state_d = S_WB;
        end else if (is_load || is_store) begin
          aluop   = 3'b100;
          state_d = S_MEM;
        end else begin
          // Jumps, branches and NOPs finish here. Branches test the flags
          // captured by the last ALU instruction, not the live ALU flags.
          retire  = 1'b1;
          state_d = S_FETCH;
          if (is_j || (is_brz && z_q) || (is_brn && n_q)) begin
            pc_we  = 1'b1;
            pc_src = 1'b1;
          end
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (!mem_ack) begin
          state_d = S_MEM;
        end else if (is_store) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        reg_src = is_load;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset silences every control strobe in the same cycle, which is what
    // abandons an in-flight instruction without side effects.
    if (rst) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_src   = 1'b0;
      reg_we   = 1'b0;
      reg_src  = 1'b0;
      alusrc   = 1'b0;
      aluop    = 3'b000;
      retire   = 1'b0;
      state_d  = S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (state_q == S_EXEC && is_alu) begin
        z_q <= alu_z;
        n_q <= alu_n;
      end
      if (retire) begin
        cnt_q <= cnt_q + 16'h0001;
      end
    end
  end

  assign retired_cnt = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// tb_multicycle_seq -- directed bench for multicycle_seq.
// Each driven cycle pushes the hand-written expected output word into
// exp_q; the monitor pops one entry on every falling edge and compares it
// with the DUT outputs. Word layout:
//   [31:16] retired_cnt, [15:13] state, [12] mem_req, [11] mem_we,
//   [10] addr_sel, [9] ir_we, [8] pc_we, [7] pc_src, [6] reg_we,
//   [5] reg_src, [4] alusrc, [3:1] aluop, [0] retire
module tb_multicycle_seq;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic        alu_z;
  logic        alu_n;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic        pc_src;
  logic        reg_we;
  logic        reg_src;
  logic        alusrc;
  logic [2:0]  aluop;
  logic        retire;
  logic [15:0] retired_cnt;
  logic [2:0]  state;

  multicycle_seq dut (
    .clk         (clk),
    .rst         (rst),
    .inst        (inst),
    .alu_z       (alu_z),
    .alu_n       (alu_n),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .addr_sel    (addr_sel),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_src      (pc_src),
    .reg_we      (reg_we),
    .reg_src     (reg_src),
    .alusrc      (alusrc),
    .aluop       (aluop),
    .retire      (retire),
    .retired_cnt (retired_cnt),
    .state       (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = 16'h0000;

  localparam logic [31:0] I_ADD   = 32'h4000_0000;
  localparam logic [31:0] I_ADDI  = 32'h5000_0000;
  localparam logic [31:0] I_SUB   = 32'h6000_0000;
  localparam logic [31:0] I_AND   = 32'h7000_0000;
  localparam logic [31:0] I_LOAD  = 32'hE000_0000;
  localparam logic [31:0] I_STORE = 32'h3000_0000;
  localparam logic [31:0] I_J     = 32'h8000_0000;
  localparam logic [31:0] I_BRZ   = 32'h9000_0000;
  localparam logic [31:0] I_BRN   = 32'hB000_0000;
  localparam logic [31:0] I_SVPC  = 32'hF000_0000;
  localparam logic [31:0] I_NOP   = 32'h0000_0000;

  // Build a 16-bit control word: state, {mem_req, mem_we, addr_sel, ir_we,
  // pc_we, pc_src, reg_we, reg_src, alusrc}, aluop, retire.
  function automatic logic [15:0] cw(input logic [2:0] st, input logic [8:0] f,
                                     input logic [2:0] aop, input logic ret);
    cw = {st, f, aop, ret};
  endfunction

  always @(negedge clk) begin
    logic [31:0] e;
    logic [31:0] a;
    string       t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {retired_cnt, state, mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src,
           reg_we, reg_src, alusrc, aluop, retire};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", t, a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [31:0] i, input logic ack, input logic z,
                      input logic n, input logic r, input logic chk,
                      input logic [15:0] c, input string tag);
    inst    = i;
    mem_ack = ack;
    alu_z   = z;
    alu_n   = n;
    rst     = r;
    if (chk) begin
      exp_q.push_back({exp_cnt, c});
      tag_q.push_back(tag);
    end
    @(posedge clk);
    #1;
    if (r) exp_cnt = 16'h0000;
    else if (c[0]) exp_cnt = exp_cnt + 16'h0001;
  endtask

  // FETCH with some unacknowledged cycles; inst carries junk opcodes that
  // must not influence anything.
  task automatic fetch(input int waits, input string tag);
    for (int k = 0; k < waits; k++)
      step((k % 2 == 0) ? I_STORE : I_J, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
           cw(3'd0, 9'b101_000_000, 3'b000, 1'b0), tag);
    step(I_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
         cw(3'd0, 9'b101_110_000, 3'b000, 1'b0), tag);
  endtask

  task automatic alu_instr(input logic [31:0] i, input logic [2:0] aop,
                           input logic asrc, input logic z, input logic n,
                           input string tag);
    fetch(0, tag);
    step(i, 1'b1, ~z, ~n, 1'b0, 1'b1, cw(3'd1, 9'b0, 3'b000, 1'b0), tag);
    step(i, 1'b1, z, n, 1'b0, 1'b1, cw(3'd2, {8'b0, asrc}, aop, 1'b0), tag);
    step(i, 1'b1, ~z, ~n, 1'b0, 1'b1, cw(3'd4, 9'b000_000_100, 3'b000, 1'b1), tag);
  endtask

  // Jumps, branches, NOPs: retire in EXEC, optionally loading the PC target.
  task automatic short_instr(input logic [31:0] i, input logic taken,
                             input logic zl, input logic nl, input int waits,
                             input string tag);
    fetch(waits, tag);
    step(i, 1'b1, zl, nl, 1'b0, 1'b1, cw(3'd1, 9'b0, 3'b000, 1'b0), tag);
    step(i, 1'b1, zl, nl, 1'b0, 1'b1,
         cw(3'd2, taken ? 9'b000_011_000 : 9'b0, 3'b000, 1'b1), tag);
  endtask

  task automatic svpc_instr(input logic zl, input logic nl, input string tag);
    fetch(0, tag);
    step(I_SVPC, 1'b1, zl, nl, 1'b0, 1'b1, cw(3'd1, 9'b0, 3'b000, 1'b0), tag);
    step(I_SVPC, 1'b1, zl, nl, 1'b0, 1'b1, cw(3'd2, 9'b000_000_001, 3'b100, 1'b0), tag);
    step(I_SVPC, 1'b1, zl, nl, 1'b0, 1'b1, cw(3'd4, 9'b000_000_100, 3'b000, 1'b1), tag);
  endtask

  task automatic load_instr(input int delay, input string tag);
    fetch(0, tag);
    step(I_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, cw(3'd1, 9'b0, 3'b000, 1'b0), tag);
    step(I_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, cw(3'd2, 9'b0, 3'b100, 1'b0), tag);
    for (int k = 0; k < delay; k++)
      step(I_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cw(3'd3, 9'b100_000_000, 3'b000, 1'b0), tag);
    step(I_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, cw(3'd3, 9'b100_000_000, 3'b000, 1'b0), tag);
    step(I_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, cw(3'd4, 9'b000_000_110, 3'b000, 1'b1), tag);
  endtask

  task automatic store_instr(input int delay, input string tag);
    fetch(0, tag);
    step(I_STORE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, cw(3'd1, 9'b0, 3'b000, 1'b0), tag);
    step(I_STORE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, cw(3'd2, 9'b0, 3'b100, 1'b0), tag);
    for (int k = 0; k < delay; k++)
      step(I_STORE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cw(3'd3, 9'b110_000_000, 3'b000, 1'b0), tag);
    step(I_STORE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, cw(3'd3, 9'b110_000_000, 3'b000, 1'b1), tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; inst = '0; alu_z = 1'b0; alu_n = 1'b0; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    step(I_NOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cw(3'd0, 9'b0, 3'b000, 1'b0), "init");
    step(I_NOP, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, cw(3'd0, 9'b0, 3'b000, 1'b0), "reset_state");
    step(I_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cw(3'd0, 9'b101_000_000, 3'b000, 1'b0), "post_rst");

    alu_instr(I_ADD, 3'b100, 1'b0, 1'b1, 1'b0, "alu_add");
    short_instr(I_BRZ, 1'b1, 1'b0, 1'b1, 0, "brz_taken_zq");
    short_instr(I_BRN, 1'b0, 1'b0, 1'b1, 0, "brn_not_taken");
    alu_instr(I_ADDI, 3'b100, 1'b1, 1'b0, 1'b1, "alu_addi");
    alu_instr(I_SUB, 3'b010, 1'b0, 1'b0, 1'b1, "alu_sub");
    svpc_instr(1'b1, 1'b0, "svpc");
    short_instr(I_BRN, 1'b1, 1'b1, 1'b0, 2, "brn_taken_nq");
    short_instr(I_BRZ, 1'b0, 1'b1, 1'b0, 1, "brz_not_taken");
    alu_instr(I_AND, 3'b001, 1'b0, 1'b0, 1'b0, "alu_and");
    short_instr(I_J, 1'b1, 1'b0, 1'b0, 0, "jump");
    short_instr(32'h0000_0000, 1'b0, 1'b1, 1'b1, 0, "nop_0000");
    short_instr(32'h1234_5678, 1'b0, 1'b1, 1'b1, 3, "nop_0001");
    short_instr(32'h2FFF_FFFF, 1'b0, 1'b1, 1'b1, 0, "nop_0010");
    short_instr(32'hA000_0001, 1'b0, 1'b1, 1'b1, 0, "nop_1010");
    short_instr(32'hC000_0000, 1'b0, 1'b1, 1'b1, 0, "nop_1100");
    short_instr(32'hD000_0000, 1'b0, 1'b1, 1'b1, 0, "nop_1101");
    load_instr(3, "load_slow");
    load_instr(0, "load_fast");
    store_instr(1, "store");

    // Reset while a STORE waits in MEM: no retire, counter cleared.
    fetch(0, "rst_mem");
    step(I_STORE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, cw(3'd1, 9'b0, 3'b000, 1'b0), "rst_mem");
    step(I_STORE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, cw(3'd2, 9'b0, 3'b100, 1'b0), "rst_mem");
    step(I_STORE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cw(3'd3, 9'b110_000_000, 3'b000, 1'b0), "rst_mem");
    step(I_STORE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, cw(3'd3, 9'b0, 3'b000, 1'b0), "rst_mem_assert");
    step(I_STORE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, cw(3'd0, 9'b0, 3'b000, 1'b0), "rst_mem_after");
    step(I_STORE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cw(3'd0, 9'b101_000_000, 3'b000, 1'b0), "rst_mem_release");

    // Reset during a jump's EXEC cycle: the PC load is suppressed.
    short_instr(I_NOP, 1'b0, 1'b0, 1'b0, 0, "pre_rst_exec");
    fetch(0, "rst_exec");
    step(I_J, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, cw(3'd1, 9'b0, 3'b000, 1'b0), "rst_exec");
    step(I_J, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, cw(3'd2, 9'b0, 3'b000, 1'b0), "rst_exec_assert");
    step(I_J, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, cw(3'd0, 9'b101_110_000, 3'b000, 1'b0), "rst_exec_release");
    step(I_NOP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, cw(3'd1, 9'b0, 3'b000, 1'b0), "rst_exec_dec");
    step(I_NOP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, cw(3'd2, 9'b0, 3'b000, 1'b1), "rst_exec_nop");

    // Counter wrap: clear, then 65536 NOPs bring retired_cnt back to 0000.
    step(I_NOP, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, cw(3'd0, 9'b0, 3'b000, 1'b0), "wrap_rst");
    for (int k = 0; k < 65536; k++)
      short_instr(I_NOP, 1'b0, 1'b0, 1'b0, 0, "wrap_nop");
    step(I_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cw(3'd0, 9'b101_000_000, 3'b000, 1'b0), "wrap_done");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_seq.md
MULTICYCLE_SEQ -- requirements
Module: multicycle_seq

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port inst, input, 32 bits: instruction register contents; opcode = inst[31:28].
REQ-004 The block SHALL have the ports alu_z and alu_n, input, 1 bit each: zero and negative flags from the ALU, valid during EXEC.
REQ-005 The block SHALL have the port mem_ack, input, 1 bit: the memory completes the current request in the cycle this is high.
REQ-006 The block SHALL have the ports mem_req and mem_we, output, 1 bit each: memory request and write enable.
REQ-007 The block SHALL have the port addr_sel, output, 1 bit: memory address source, 1 = PC, 0 = ALU result.
REQ-008 The block SHALL have the ports ir_we, pc_we and pc_src, output, 1 bit each: IR load, PC load, and PC source (0 = PC+1, 1 = register target).
REQ-009 The block SHALL have the ports reg_we and reg_src, output, 1 bit each: register write enable and write-data source (0 = ALU, 1 = memory).
REQ-010 The block SHALL have the ports alusrc, output, 1 bit, and aluop, output, 3 bits: ALU controls.
REQ-011 The block SHALL have the port retire, output, 1 bit: one-cycle pulse when an instruction completes.
REQ-012 The block SHALL have the port retired_cnt, output, 16 bits: count of completed instructions.
REQ-013 The block SHALL have the port state, output, 3 bits: current FSM state code.

Function
REQ-014 The block SHALL decode the opcode as follows:
- 0100..0111: ALU class
- 1110: LOAD
- 0011: STORE
- 1000: J
- 1001: BRZ
- 1011: BRN
- 1111: SVPC
- any other code: NOP
REQ-015 The FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5..7 SHALL go to FETCH on the next cycle with all outputs low.
REQ-016 In FETCH, the block SHALL hold mem_req=1, mem_we=0, addr_sel=1.
- It SHALL stay in FETCH until mem_ack=1.
- In the mem_ack cycle it SHALL pulse ir_we=1 and pc_we=1 with pc_src=0, and go to DECODE.
REQ-017 DECODE SHALL last exactly one cycle, assert no outputs, and go to EXEC.
REQ-018 In EXEC, the ALU class SHALL drive the following, and then go to WB:
- aluop=100 for 0100 and 0101, 010 for 0110, 001 for 0111
- alusrc=1 only for 0101
- the flag registers z_q and n_q SHALL be loaded from alu_z and alu_n
REQ-019 In EXEC, SVPC SHALL drive aluop=100, alusrc=1, and go to WB; flags SHALL be unchanged.
REQ-020 In EXEC, LOAD and STORE SHALL drive aluop=100, alusrc=0, and go to MEM.
REQ-021 In EXEC, J, BRZ and BRN SHALL go to FETCH.
- J SHALL assert pc_we=1 with pc_src=1.
- BRZ SHALL do the same only if z_q=1; BRN only if n_q=1.
- Branches SHALL use the registered flags, never the live alu_z or alu_n.
REQ-022 In EXEC, NOP SHALL go to FETCH with no side effects.
REQ-023 Outside the EXEC cases listed, aluop SHALL be 000 and alusrc SHALL be 0.
REQ-024 In MEM, the block SHALL hold mem_req=1, addr_sel=0, and mem_we=1 only for STORE.
- It SHALL wait for mem_ack=1.
- On ack, LOAD SHALL go to WB and STORE SHALL go to FETCH.
REQ-025 WB SHALL last exactly one cycle with reg_we=1, then go to FETCH.
- reg_src=1 for LOAD; reg_src=0 otherwise.
REQ-026 retire SHALL pulse high in the final cycle of each instruction: the cycle whose next state is FETCH from EXEC, MEM or WB.
REQ-027 retired_cnt SHALL increment on each retire and wrap from FFFF to 0000.
REQ-028 mem_ack SHALL be ignored outside FETCH and MEM, and mem_req SHALL never be high in DECODE, EXEC or WB.
REQ-029 With mem_ack tied high, latency from FETCH entry to retire SHALL be:
- ALU and SVPC: 4 cycles
- LOAD: 5 cycles
- STORE: 4 cycles
- J, branches and NOP: 3 cycles
REQ-030 inst SHALL be sampled only in DECODE, EXEC, MEM and WB; changes to inst during FETCH SHALL have no effect.

Reset
REQ-031 When rst=1 at a clock edge, the block SHALL set state=FETCH, z_q=0, n_q=0 and retired_cnt=0.
REQ-032 While rst=1, all control outputs, including mem_req and retire, SHALL be 0.
REQ-033 A reset asserted mid-instruction, including during a pending MEM request, SHALL abandon the instruction with no pc_we, reg_we or retire.
REQ-034 The first cycle after rst deasserts SHALL be FETCH with mem_req=1.

Verification
REQ-035 The bench SHALL cover ALU add with mem_ack held high: inst opcode 0100 -> ir_we at cycle 0, aluop=100 at cycle 2, reg_we=1 with reg_src=0 at cycle 3, retire at cycle 3, retired_cnt=1.
REQ-036 The bench SHALL cover LOAD with mem_ack delayed 3 cycles in MEM: opcode 1110 -> mem_req=1 with addr_sel=0 held for 4 cycles, then WB with reg_src=1, and retire 8 cycles after FETCH entry.
REQ-037 The bench SHALL cover branches using registered flags:
- ALU op with alu_z=1, then BRZ (1001) with alu_z=0 -> pc_we=1 and pc_src=1 in EXEC.
- BRN (1011) with n_q=0 -> no pc_we in EXEC.
REQ-038 The bench SHALL cover STORE: opcode 0011 -> mem_we=1 only in MEM, and reg_we never asserted.
REQ-039 The bench SHALL cover reset in MEM: rst=1 during a pending STORE with mem_ack=0 -> next cycle state=0 and mem_req=0; retired_cnt=0, and no retire pulse.
REQ-040 The bench SHALL cover counter wrap: preload via 65536 NOPs (0000) -> retired_cnt returns to 0000 and retire pulses every 3rd cycle.
